// File: rtl/spi_cmd_decoder_if.sv
// Byte-in / command-out bundle between the SPI byte receiver, the decoder and the core.
// The master drives the receiver side (cs_n, rx_*); the slave (decoder) drives the command side.
interface spi_cmd_decoder_if #(
    parameter int unsigned ABORT_CNT_W = 8
);
    logic                   cs_n;
    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   cmd_valid;
    logic [7:0]             cmd_opcode;
    logic [31:0]            cmd_data;
    logic                   cmd_long;
    logic                   soft_reset;
    logic                   arm;
    logic                   query_id;
    logic                   query_meta;
    logic                   rle_finish;
    logic                   busy;
    logic [ABORT_CNT_W-1:0] abort_cnt;

    modport master (
        output cs_n, rx_valid, rx_data,
        input  cmd_valid, cmd_opcode, cmd_data, cmd_long, soft_reset, arm, query_id,
               query_meta, rle_finish, busy, abort_cnt
    );

    modport slave (
        input  cs_n, rx_valid, rx_data,
        output cmd_valid, cmd_opcode, cmd_data, cmd_long, soft_reset, arm, query_id,
               query_meta, rle_finish, busy, abort_cnt
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Assembles SPI bytes into short (1-byte) and long (opcode + 4 LS-first bytes) host commands.
// Optional inter-byte idle timeout is built only when SPI_CMD_TIMEOUT_EN is defined.
module spi_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ABORT_CNT_W    = 8
) (
    input logic               clock,
    input logic               reset_n,
    spi_cmd_decoder_if.slave  bus
);
    typedef enum logic {StIdle, StArg} state_e;

    state_e                 state_q, state_d;
    logic                   cs_q;
    logic [1:0]             arg_idx_q, arg_idx_d;
    logic [23:0]            arg_q, arg_d;
    logic [7:0]             opcode_q, opcode_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             cmd_opcode_q, cmd_opcode_d;
    logic [31:0]            cmd_data_q, cmd_data_d;
    logic                   cmd_long_q, cmd_long_d;
    logic [4:0]             strobe_q, strobe_d;
    logic [ABORT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;

    logic cs_rise;
    logic byte_ok;
    logic timeout_hit;

    assign cs_rise = bus.cs_n & ~cs_q;
    // The byte arriving on the cs_n rise cycle still belongs to the frame
    assign byte_ok = bus.rx_valid & (~bus.cs_n | cs_rise);

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int unsigned IdleW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [IdleW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d      = '0;
        timeout_hit = 1'b0;
        if (state_q == StArg && !byte_ok) begin
            idle_d      = idle_q + 1'b1;
            timeout_hit = (idle_q == IdleW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT_CYCLES only matters when the idle timeout is built
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d      = state_q;
        arg_idx_d    = arg_idx_q;
        arg_d        = arg_q;
        opcode_d     = opcode_q;
        cmd_valid_d  = 1'b0;
        cmd_opcode_d = cmd_opcode_q;
        cmd_data_d   = cmd_data_q;
        cmd_long_d   = cmd_long_q;
        strobe_d     = '0;
        abort_cnt_d  = abort_cnt_q;

        case (state_q)
            StIdle: begin
                if (byte_ok) begin
                    if (bus.rx_data[7]) begin
                        opcode_d  = bus.rx_data;
                        arg_idx_d = 2'd0;
                        state_d   = StArg;
                    end else begin
                        cmd_valid_d  = 1'b1;
                        cmd_opcode_d = bus.rx_data;
                        cmd_data_d   = '0;
                        cmd_long_d   = 1'b0;
                        case (bus.rx_data)
                            8'h00:   strobe_d = 5'b10000;
                            8'h01:   strobe_d = 5'b01000;
                            8'h02:   strobe_d = 5'b00100;
                            8'h04:   strobe_d = 5'b00010;
                            8'h05:   strobe_d = 5'b00001;
                            default: strobe_d = 5'b00000;
                        endcase
                    end
                end
            end
            StArg: begin
                if (byte_ok) begin
                    if (arg_idx_q == 2'd3) begin
                        cmd_valid_d  = 1'b1;
                        cmd_opcode_d = opcode_q;
                        cmd_data_d   = {bus.rx_data, arg_q};
                        cmd_long_d   = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        case (arg_idx_q)
                            2'd0:    arg_d[7:0]   = bus.rx_data;
                            2'd1:    arg_d[15:8]  = bus.rx_data;
                            default: arg_d[23:16] = bus.rx_data;
                        endcase
                        arg_idx_d = arg_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort only what is still partial after this cycle's byte has been taken
        if ((cs_rise || timeout_hit) && state_d == StArg) begin
            state_d = StIdle;
            if (abort_cnt_q != '1) begin
                abort_cnt_d = abort_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cs_q         <= 1'b1;
            arg_idx_q    <= '0;
            arg_q        <= '0;
            opcode_q     <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_opcode_q <= '0;
            cmd_data_q   <= '0;
            cmd_long_q   <= 1'b0;
            strobe_q     <= '0;
            abort_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cs_q         <= bus.cs_n;
            arg_idx_q    <= arg_idx_d;
            arg_q        <= arg_d;
            opcode_q     <= opcode_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_opcode_q <= cmd_opcode_d;
            cmd_data_q   <= cmd_data_d;
            cmd_long_q   <= cmd_long_d;
            strobe_q     <= strobe_d;
            abort_cnt_q  <= abort_cnt_d;
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_opcode = cmd_opcode_q;
    assign bus.cmd_data   = cmd_data_q;
    assign bus.cmd_long   = cmd_long_q;
    assign bus.soft_reset = strobe_q[4];
    assign bus.arm        = strobe_q[3];
    assign bus.query_id   = strobe_q[2];
    assign bus.query_meta = strobe_q[1];
    assign bus.rle_finish = strobe_q[0];
    assign bus.busy       = (state_q == StArg);
    assign bus.abort_cnt  = abort_cnt_q;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: a frame-level byte-queue model predicts commands,
// busy and abort_cnt; a negedge monitor compares them against the DUT.
module tb_spi_cmd_decoder;
    localparam int unsigned TimeoutCycles = 16;
    localparam int unsigned AbortW        = 8;
    localparam int          AbortMax      = (1 << AbortW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    spi_cmd_decoder_if #(.ABORT_CNT_W(AbortW)) bus ();

    spi_cmd_decoder #(
        .TIMEOUT_CYCLES (TimeoutCycles),
        .ABORT_CNT_W    (AbortW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] data;
        logic        lng;
        logic [4:0]  stb;
        int          cyc;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_frame[$];
    int         m_abort   = 0;
    int         m_idle    = 0;
    bit         m_cs_prev = 1'b1;
    bit         exp_busy  = 1'b0;
    int         exp_abort = 0;
    int         n_cmp     = 0;
    int         n_bad     = 0;
    int         cyc       = 0;

    always @(posedge clock) begin
        cyc       <= cyc + 1;
        exp_busy  <= (m_frame.size() != 0);
        exp_abort <= m_abort;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] stb_of(input logic [7:0] op);
        case (op)
            8'h00:   return 5'b10000;
            8'h01:   return 5'b01000;
            8'h02:   return 5'b00100;
            8'h04:   return 5'b00010;
            8'h05:   return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic model_abort();
        m_frame.delete();
        m_idle = 0;
        if (m_abort < AbortMax) m_abort++;
    endtask

    // Frame-level reference: a partial long command is just a non-empty byte queue
    task automatic model_step(input bit v, input logic [7:0] d, input bit cs);
        bit   rise;
        bit   ok;
        exp_t e;
        rise = cs && !m_cs_prev;
        ok   = v && (!cs || rise);
        if (ok) begin
            m_idle = 0;
            if (m_frame.size() == 0 && !d[7]) begin
                e.op = d; e.data = 32'h0; e.lng = 1'b0; e.stb = stb_of(d); e.cyc = cyc + 1;
                sb_q.push_back(e);
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == 5) begin
                    e.op   = m_frame[0];
                    e.data = {m_frame[4], m_frame[3], m_frame[2], m_frame[1]};
                    e.lng  = 1'b1; e.stb = 5'b0; e.cyc = cyc + 1;
                    sb_q.push_back(e);
                    m_frame.delete();
                end
            end
        end else if (m_frame.size() != 0) begin
`ifdef SPI_CMD_TIMEOUT_EN
            if (m_idle == int'(TimeoutCycles) - 1) model_abort();
            else m_idle++;
`endif
        end
        if (rise && m_frame.size() != 0) model_abort();
        m_cs_prev = cs;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit cs);
        @(posedge clock);
        #1;
        bus.cs_n     = cs;
        bus.rx_valid = v;
        bus.rx_data  = d;
        model_step(v, d, cs);
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_valid"}, 64'(bus.cmd_valid), 64'd0);
        chk({tag, "_cmd_opcode"}, 64'(bus.cmd_opcode), 64'd0);
        chk({tag, "_cmd_data"}, 64'(bus.cmd_data), 64'd0);
        chk({tag, "_cmd_long"}, 64'(bus.cmd_long), 64'd0);
        chk({tag, "_strobes"}, 64'({bus.soft_reset, bus.arm, bus.query_id, bus.query_meta,
                                     bus.rle_finish}), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_abort_cnt"}, 64'(bus.abort_cnt), 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a command
    exp_t mon_e;
    always @(negedge clock) begin
        if (reset_n) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                mon_e = sb_q.pop_front();
                chk("missing_cmd_valid", 64'd0, 64'd1);
            end
            if (bus.cmd_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_cmd_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("cmd_latency", 64'(cyc), 64'(mon_e.cyc));
                    chk("cmd_opcode", 64'(bus.cmd_opcode), 64'(mon_e.op));
                    chk("cmd_data", 64'(bus.cmd_data), 64'(mon_e.data));
                    chk("cmd_long", 64'(bus.cmd_long), 64'(mon_e.lng));
                    chk("strobes", 64'({bus.soft_reset, bus.arm, bus.query_id, bus.query_meta,
                                        bus.rle_finish}), 64'(mon_e.stb));
                end
            end else if ({bus.soft_reset, bus.arm, bus.query_id, bus.query_meta,
                          bus.rle_finish} != 5'b0) begin
                chk("strobe_without_cmd_valid", 64'({bus.soft_reset, bus.arm, bus.query_id,
                    bus.query_meta, bus.rle_finish}), 64'd0);
            end
            chk("busy", 64'(bus.busy), 64'(exp_busy));
            chk("abort_cnt", 64'(bus.abort_cnt), 64'(exp_abort));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] shorts[6];
        bit         rcs;
        bit         rv;
        logic [7:0] rd;
        shorts = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h7F};

        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("in_reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs("after_reset");

        drive(1'b0, 8'h00, 1'b0);
        repeat (5) send(8'h00);
        drive(1'b0, 8'h00, 1'b0);

        send(8'hC0); send(8'hFF); send(8'h00); send(8'h00); send(8'h00);
        drive(1'b0, 8'h00, 1'b0);

        send(8'h82); send(8'h00); send(8'h08); send(8'h00); send(8'h00);
        send(8'h01);
        drive(1'b0, 8'h00, 1'b0);

        send(8'h81); send(8'h0F); send(8'h00);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        send(8'h02);
        send(8'h7F); send(8'h04); send(8'h05); send(8'h33);
        drive(1'b1, 8'h01, 1'b1);  // byte while cs_n high and already high next cycle
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        send(8'h80); send(8'h02); send(8'h00); send(8'h00);
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        send(8'h90); send(8'hA5); send(8'h5A); send(8'h81); send(8'hFF);
        drive(1'b0, 8'h00, 1'b0);

        send(8'hC2); send(8'h00);
        repeat (16) drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
`ifdef SPI_CMD_TIMEOUT_EN
        chk("timeout_busy", 64'(bus.busy), 64'd0);
`else
        chk("no_timeout_busy", 64'(bus.busy), 64'd1);
`endif
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        rcs = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!rcs && $urandom_range(0, 99) < 6) rcs = 1'b1;
            else if (rcs && $urandom_range(0, 99) < 50) rcs = 1'b0;
            rv = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) rd = shorts[$urandom_range(0, 5)];
            else rd = 8'($urandom);
            drive(rv, rd, rcs);
        end
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        send(8'h85); send(8'h11);
        @(posedge clock);
        #1;
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        reset_n      = 1'b0;
        m_frame.delete();
        m_abort   = 0;
        m_idle    = 0;
        m_cs_prev = 1'b1;
        #2;
        check_reset_outputs("mid_cmd_reset");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 260; i++) begin
            send(8'h81);
            drive(1'b0, 8'h00, 1'b1);
            drive(1'b0, 8'h00, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("abort_saturated", 64'(bus.abort_cnt), 64'(AbortMax));

        repeat (5) drive(1'b0, 8'h00, 1'b0);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
